// File: rtl/mantissa_div_pkg.sv
// Shared state encoding and sizing helpers for the sequential mantissa divider.
package mantissa_div_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // Smallest width (>=1) able to hold values 0..v-1.
   function automatic int cnt_width(input int v);
      int w;
      w = 1;
      while ((1 << w) < v) w++;
      return w;
   endfunction

endpackage

// File: rtl/mantissa_seq_div_if.sv
// Operand/result handshake bundle for the sequential mantissa divider.
interface mantissa_seq_div_if #(
   parameter int BASELINE       = 15,
   parameter int MANTISSA_WIDTH = 15
);
   logic                                        in_valid;
   logic                                        in_ready;
   logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]   Mantissa_X;
   logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]   Mantissa_Y;
   logic                                        out_valid;
   logic                                        out_ready;
   logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]   Mantissa_Out;
   logic                                        Exp_Dec;
   logic                                        Sticky;

   modport master (
      output in_valid, Mantissa_X, Mantissa_Y, out_ready,
      input  in_ready, out_valid, Mantissa_Out, Exp_Dec, Sticky
   );

   modport slave (
      input  in_valid, Mantissa_X, Mantissa_Y, out_ready,
      output in_ready, out_valid, Mantissa_Out, Exp_Dec, Sticky
   );
endinterface

// File: rtl/mantissa_div_step.sv
// One restoring-division step: optional left shift, trial subtract, quotient bit.
module mantissa_div_step #(
   parameter int W = 15
) (
   input  logic [W+1:0] i_r,
   input  logic [W:0]   i_d,
   input  logic         i_shift,
   output logic [W+1:0] o_r,
   output logic         o_q
);
   logic [W+1:0] w_sh;
   logic [W+1:0] w_dx;

   assign w_sh = i_shift ? {i_r[W:0], 1'b0} : i_r;
   assign w_dx = {1'b0, i_d};
   assign o_q  = (w_sh >= w_dx);
   assign o_r  = o_q ? (w_sh - w_dx) : w_sh;
endmodule

// File: rtl/mantissa_seq_div.sv
// Iterative restoring divider 1.X / 1.Y with renormalization, sticky and
// midpoint compensation for the fraction bits beyond ITER.
module mantissa_seq_div
   import mantissa_div_pkg::*;
#(
   parameter int BASELINE       = 15,
   parameter int MANTISSA_WIDTH = 15,
   parameter int ITER           = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   mantissa_seq_div_if.slave bus
);
   localparam int W  = MANTISSA_WIDTH;
   localparam int CW = cnt_width(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   logic [1:0]      r_state;
   logic [W+1:0]    r_r;
   logic [W:0]      r_d;
   logic [ITER-1:0] r_q;
   logic [CW-1:0]   r_cnt;
   logic            r_exp_dec;
   logic [W-1:0]    r_out;
   logic            r_sticky;
   logic            r_ov;

   logic [BASELINE-1:BASELINE-MANTISSA_WIDTH] w_x, w_y;
   logic [W+1:0]    w_r_nxt;
   logic            w_qbit, w_lt, w_shift, w_sticky;
   logic [ITER-1:0] w_q_nxt;
   logic [W-1:0]    w_out;

   assign w_x      = bus.Mantissa_X;
   assign w_y      = bus.Mantissa_Y;
   // In NORM r_r still holds A, so this is the X<Y renormalization test.
   assign w_lt     = (r_r < {1'b0, r_d});
   assign w_shift  = (r_state == mantissa_div_pkg::ITER) | w_lt;
   assign w_sticky = |r_r;

   mantissa_div_step #(.W(W)) u_step (
      .i_r     (r_r),
      .i_d     (r_d),
      .i_shift (w_shift),
      .o_r     (w_r_nxt),
      .o_q     (w_qbit)
   );

   generate
      if (ITER == 1) begin : g_q1
         assign w_q_nxt = w_qbit;
      end else begin : g_qn
         assign w_q_nxt = {r_q[ITER-2:0], w_qbit};
      end

      if (ITER == W) begin : g_exact
         assign w_out = r_q;
      end else if (ITER == W - 1) begin : g_mid1
         assign w_out = {r_q, w_sticky};
      end else begin : g_mid
         assign w_out = {r_q, w_sticky, {(W-ITER-1){1'b0}}};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_r       <= '0;
         r_d       <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_exp_dec <= 1'b0;
         r_out     <= '0;
         r_sticky  <= 1'b0;
         r_ov      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_r     <= {2'b01, w_x};
               r_d     <= {1'b1, w_y};
               r_q     <= '0;
               r_state <= NORM;
            end
            NORM: begin
               r_r       <= w_r_nxt;
               r_exp_dec <= w_lt;
               r_cnt     <= '0;
               r_state   <= mantissa_div_pkg::ITER;
            end
            mantissa_div_pkg::ITER: begin
               r_r   <= w_r_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) r_state <= DONE;
            end
            DONE: begin
               // First DONE cycle captures the assembled result; then hold it.
               if (!r_ov) begin
                  r_ov     <= 1'b1;
                  r_out    <= w_out;
                  r_sticky <= w_sticky;
               end else if (bus.out_ready) begin
                  r_ov    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (r_state == IDLE);
   assign bus.out_valid    = r_ov;
   assign bus.Mantissa_Out = r_out;
   assign bus.Exp_Dec      = r_exp_dec;
   assign bus.Sticky       = r_sticky;
endmodule

// File: tb/tb_mantissa_seq_div.sv
// Bench for mantissa_seq_div: ITER=15 and ITER=8 instances checked against
// an arithmetic (integer division) reference model.
module tb_mantissa_seq_div;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic        sel = 1'b0;   // 0: ITER=15 instance, 1: ITER=8 instance
   logic        iv = 1'b0;
   logic        ordy = 1'b0;
   logic [14:0] tx = '0, ty = '0;

   mantissa_seq_div_if #(.BASELINE(15), .MANTISSA_WIDTH(15)) bus15 ();
   mantissa_seq_div_if #(.BASELINE(15), .MANTISSA_WIDTH(15)) bus8 ();

   assign bus15.in_valid   = iv & ~sel;
   assign bus8.in_valid    = iv & sel;
   assign bus15.Mantissa_X = tx;
   assign bus15.Mantissa_Y = ty;
   assign bus8.Mantissa_X  = tx;
   assign bus8.Mantissa_Y  = ty;
   assign bus15.out_ready  = ordy;
   assign bus8.out_ready   = ordy;

   mantissa_seq_div #(.BASELINE(15), .MANTISSA_WIDTH(15), .ITER(15)) u15 (
      .clk(clk), .rst_n(rst_n), .bus(bus15.slave));
   mantissa_seq_div #(.BASELINE(15), .MANTISSA_WIDTH(15), .ITER(8)) u8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   logic        o_ir, o_ov, o_ed, o_st;
   logic [14:0] o_mo;
   always_comb begin
      o_ir = sel ? bus8.in_ready     : bus15.in_ready;
      o_ov = sel ? bus8.out_valid    : bus15.out_valid;
      o_ed = sel ? bus8.Exp_Dec      : bus15.Exp_Dec;
      o_st = sel ? bus8.Sticky       : bus15.Sticky;
      o_mo = sel ? bus8.Mantissa_Out : bus15.Mantissa_Out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Exact quotient of (1.X)/(1.Y), scaled by 2^iter after renormalization.
   task automatic model(input int iter, input logic [14:0] x, input logic [14:0] y,
                        output logic [14:0] m, output logic ed, output logic st);
      longint a, d, n, qf, q;
      a  = 32768 + longint'(x);
      d  = 32768 + longint'(y);
      ed = (a < d);
      n  = (ed ? 2 * a : a) << iter;
      qf = n / d;
      st = (n % d) != 0;
      q  = qf - (longint'(1) << iter);
      if (iter == 15) m = 15'(q);
      else m = 15'((q << (15 - iter)) | (longint'(st) << (14 - iter)));
   endtask

   // Issue one operation on the selected instance, check latency and result,
   // optionally stall the result for `hold` cycles, then hand it off.
   task automatic do_op(input logic s8, input logic [14:0] x, input logic [14:0] y,
                        input int hold, input logic early);
      int          iter, lat;
      logic [14:0] em;
      logic        eed, est;
      sel  = s8;
      iter = s8 ? 8 : 15;
      model(iter, x, y, em, eed, est);
      chk("in_ready_idle", 32'(o_ir), 32'd1);
      tx = x; ty = y; iv = 1'b1; ordy = early;
      @(posedge clk); #1;
      iv = 1'b0;
      chk("in_ready_busy", 32'(o_ir), 32'd0);
      lat = 0;
      while (!o_ov && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(iter + 2));
      chk("mantissa", 32'(o_mo), 32'(em));
      chk("exp_dec", 32'(o_ed), 32'(eed));
      chk("sticky", 32'(o_st), 32'(est));
      for (int h = 0; h < hold; h++) begin
         tx = 15'($urandom); ty = 15'($urandom); iv = 1'b1;
         @(posedge clk); #1;
         chk("bp_valid", 32'(o_ov), 32'd1);
         chk("bp_in_ready", 32'(o_ir), 32'd0);
         chk("bp_mantissa", 32'(o_mo), 32'(em));
         chk("bp_flags", {30'd0, o_ed, o_st}, {30'd0, eed, est});
      end
      iv = 1'b0;
      if (!early) begin
         ordy = 1'b1;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
      end
      ordy = 1'b0;
      chk("handoff_valid", 32'(o_ov), 32'd0);
      chk("handoff_in_ready", 32'(o_ir), 32'd1);
   endtask

   initial begin
      logic [14:0] rx, ry;
      #12;
      chk("rst15_ir", 32'(bus15.in_ready), 32'd1);
      chk("rst15_ov", 32'(bus15.out_valid), 32'd0);
      chk("rst15_mo", 32'(bus15.Mantissa_Out), 32'd0);
      chk("rst15_flags", {30'd0, bus15.Exp_Dec, bus15.Sticky}, 32'd0);
      chk("rst8_ir", 32'(bus8.in_ready), 32'd1);
      chk("rst8_ov", 32'(bus8.out_valid), 32'd0);
      chk("rst8_mo", 32'(bus8.Mantissa_Out), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors with hand-derived results.
      do_op(1'b0, 15'h0000, 15'h0000, 0, 1'b0);
      chk("d0_mo", 32'(o_mo), 32'h0000);
      chk("d0_ed", 32'(o_ed), 32'd0);
      chk("d0_st", 32'(o_st), 32'd0);
      do_op(1'b0, 15'h4000, 15'h0000, 0, 1'b0);
      chk("d1_mo", 32'(o_mo), 32'h4000);
      chk("d1_ed", 32'(o_ed), 32'd0);
      chk("d1_st", 32'(o_st), 32'd0);
      do_op(1'b0, 15'h0000, 15'h4000, 0, 1'b0);
      chk("d2_mo", 32'(o_mo), 32'h2AAA);
      chk("d2_ed", 32'(o_ed), 32'd1);
      chk("d2_st", 32'(o_st), 32'd1);
      do_op(1'b1, 15'h0000, 15'h4000, 0, 1'b0);
      chk("d3_mo", 32'(o_mo), 32'h2AC0);
      chk("d3_ed", 32'(o_ed), 32'd1);
      chk("d3_st", 32'(o_st), 32'd1);

      // Extremes of the operand range.
      do_op(1'b0, 15'h7FFF, 15'h7FFF, 0, 1'b0);
      do_op(1'b0, 15'h7FFF, 15'h0000, 0, 1'b1);
      do_op(1'b0, 15'h0000, 15'h7FFF, 0, 1'b0);
      do_op(1'b1, 15'h7FFF, 15'h0000, 0, 1'b0);
      do_op(1'b1, 15'h0000, 15'h7FFF, 0, 1'b1);
      do_op(1'b1, 15'h1234, 15'h1234, 0, 1'b0);

      // Backpressure, then an immediate follow-on operation.
      do_op(1'b0, 15'h2345, 15'h6789, 5, 1'b0);
      do_op(1'b0, 15'h5A5A, 15'h0F0F, 0, 1'b0);
      do_op(1'b1, 15'h6001, 15'h1003, 5, 1'b0);

      for (int i = 0; i < 20; i++) begin
         rx = 15'($urandom); ry = 15'($urandom);
         do_op(1'b0, rx, ry, 0, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 12; i++) begin
         rx = 15'($urandom); ry = 15'($urandom);
         do_op(1'b1, rx, ry, 0, 1'($urandom_range(0, 1)));
      end

      // Reset while in the ITER phase; previous result (X<Y) is nonzero.
      do_op(1'b0, 15'h0000, 15'h4000, 0, 1'b0);
      tx = 15'h1111; ty = 15'h3333; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ir", 32'(o_ir), 32'd1);
      chk("mid_rst_ov", 32'(o_ov), 32'd0);
      chk("mid_rst_mo", 32'(o_mo), 32'd0);
      chk("mid_rst_flags", {30'd0, o_ed, o_st}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(1'b0, 15'h1111, 15'h3333, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
